ttc_trigger_info_reader: RTL and testbench
==========================================

Name: ttc_trigger_info_reader

Overview:
Consumer end of the TTC Trigger FIFO. It pops each 128-bit trigger-info word, unpacks it and checks trigger-number continuity. It then streams a two-word 64-bit event header to the readout path. For events that carry a payload, it starts a channel readout and waits for completion, bounded by a timeout. It sits between the TTC Trigger FIFO output and the command manager / readout sequencer.

Parameters:
TIMEOUT_CYCLES, 32'd40000000, clk cycles allowed between readout_start and readout_done (1 s at 40 MHz).
HDR_MARKER, 4'hA, marker nibble in header word 0 [63:60].

Ports:
clk  in  1  40 MHz TTC clock
reset_n  in  1  synchronous, active-low reset
reset_trig_num  in  1  TTC Channel B trigger-number reset; expected number returns to 1
fifo_valid  in  1  FIFO word available
fifo_data  in  128  trigger-info word
fifo_ready  out  1  pop strobe; FIFO word consumed when fifo_valid & fifo_ready
hdr_valid  out  1  header word valid
hdr_data  out  64  header word
hdr_ready  in  1  downstream accepts header word
readout_start  out  1  one-cycle pulse to start channel payload readout
readout_done  in  1  channel readout complete pulse
event_done  out  1  one-cycle pulse when an event is fully handled
state  out  3  FSM state, for status
seq_error_count  out  32  trigger-number discontinuities
format_error_count  out  32  words with nonzero fifo_data[127:103]
timeout_count  out  32  readout timeouts
last_trig_num  out  24  trigger number of the last popped word

Behaviour:
- Word layout: [43:0] timestamp, [67:44] trig_num, [91:68] event_cnt, [96:92] trig_type, [97] empty_event, [101:98] xadc_alarms, [102] empty_payload, [127:103] reserved (must be 0).
- Header word 0: {HDR_MARKER, trig_type, xadc_alarms, empty_event, empty_payload, 1'b0, trig_num, event_cnt}.
- Header word 1: {20'd0, timestamp}.
- Reset (reset_n=0 at posedge): state=IDLE. fifo_ready, hdr_valid, readout_start, event_done = 0. hdr_data=0. All counters=0. last_trig_num=0. expected_num=1.
- IDLE: fifo_ready=1 combinationally. On fifo_valid, latch fields and go to HDR0. Pop latency is 1 cycle; at most one pop per event.
- On pop:
  - If trig_num != expected_num, seq_error_count+1. Then expected_num <= trig_num+1 (24-bit wrap, so 24'hFFFFFF -> 0).
  - If reserved bits != 0, format_error_count+1. The event is still processed.
  - last_trig_num <= trig_num.
- HDR0 / HDR1: hdr_valid=1 with the registered word. hdr_data holds stable until hdr_ready; advance on hdr_valid & hdr_ready. After HDR1 is accepted:
  - if empty_event | empty_payload, go to DONE;
  - otherwise pulse readout_start for 1 cycle and go to READOUT.
- READOUT: a cycle counter starts at 0.
  - On readout_done, go to DONE.
  - When the counter reaches TIMEOUT_CYCLES-1 without readout_done, timeout_count+1 and go to DONE.
  - readout_done outside READOUT is ignored.
- DONE: event_done=1 for 1 cycle, then IDLE. A back-to-back word pops on the cycle after that; event period is at least 4 cycles.
- reset_trig_num: expected_num <= 1 next cycle. If it coincides with a pop, reset_trig_num wins; no seq check is made against the pre-reset value, but the popped number is still compared against 1.
- Counters saturate at 32'hFFFFFFFF.
- Reset mid-event: state returns to IDLE and the latched word is discarded. There is no partial header handling; the downstream resets together with this block.
- State encoding: IDLE=0, HDR0=1, HDR1=2, READOUT=3, DONE=4. Values 5–7 are illegal and go to IDLE.

Decomposition:
- Shared package/header `ttc_trig_info_defs`: field bit positions of the 128-bit word, state codes, HDR_MARKER.
- The receiver side should adopt the same field constants.
- One natural sub-module: `sat_counter32` (increment-enable, saturating, sync active-low reset), instantiated three times.

Test Plan:
- Single event, trig_num=1, event_cnt=1, type=5'd1, timestamp=44'h123, empty bits 0; hdr_ready tied 1. Expect:
  - word 0 = {4'hA, 5'd1, 4'd0, 0, 0, 0, 24'd1, 24'd1};
  - word 1 = 64'h123;
  - one readout_start; readout_done 10 cycles later gives event_done; seq_error_count=0.
- Words with trig_num 1, 2, 4 -> seq_error_count=1; a following trig_num=5 gives no further increment.
- empty_event=1 word -> two header words, no readout_start, event_done one cycle after word 1 is accepted.
- hdr_ready held low 20 cycles during HDR0 -> hdr_data stable and hdr_valid high throughout; no further fifo pop.
- TIMEOUT_CYCLES=16, no readout_done -> timeout_count=1, event_done in the 17th cycle after readout_start, then the next word pops.
- reset_trig_num pulse, then a word with trig_num=1 -> no seq error.
- fifo_data[127]=1 -> format_error_count=1.
- reset_n low during READOUT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/ttc_trig_info_defs_pkg.sv
// Shared field layout of the 128-bit TTC trigger-info word, header helpers
// and reader state codes.
package ttc_trig_info_defs;

   localparam int TS_W   = 44;
   localparam int NUM_W  = 24;
   localparam int TYPE_W = 5;
   localparam int XADC_W = 4;
   localparam int RSV_W  = 25;

   localparam int TS_LSB        = 0;
   localparam int NUM_LSB       = 44;
   localparam int EVCNT_LSB     = 68;
   localparam int TYPE_LSB      = 92;
   localparam int EMPTY_EVT_BIT = 97;
   localparam int XADC_LSB      = 98;
   localparam int EMPTY_PL_BIT  = 102;
   localparam int RSV_LSB       = 103;

   localparam logic [3:0] HDR_MARKER_DEFAULT = 4'hA;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR0    = 3'd1,
      ST_HDR1    = 3'd2,
      ST_READOUT = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   typedef struct packed {
      logic [RSV_W-1:0]  reserved;
      logic              empty_payload;
      logic [XADC_W-1:0] xadc_alarms;
      logic              empty_event;
      logic [TYPE_W-1:0] trig_type;
      logic [NUM_W-1:0]  event_cnt;
      logic [NUM_W-1:0]  trig_num;
      logic [TS_W-1:0]   timestamp;
   } trig_info_t;

   function automatic trig_info_t unpack_word(input logic [127:0] w);
      trig_info_t t;
      t.timestamp     = w[TS_LSB +: TS_W];
      t.trig_num      = w[NUM_LSB +: NUM_W];
      t.event_cnt     = w[EVCNT_LSB +: NUM_W];
      t.trig_type     = w[TYPE_LSB +: TYPE_W];
      t.empty_event   = w[EMPTY_EVT_BIT];
      t.xadc_alarms   = w[XADC_LSB +: XADC_W];
      t.empty_payload = w[EMPTY_PL_BIT];
      t.reserved      = w[RSV_LSB +: RSV_W];
      return t;
   endfunction

   function automatic logic [63:0] hdr_word0(input logic [3:0] marker, input trig_info_t t);
      return {marker, t.trig_type, t.xadc_alarms, t.empty_event, t.empty_payload,
              1'b0, t.trig_num, t.event_cnt};
   endfunction

   function automatic logic [63:0] hdr_word1(input trig_info_t t);
      return {20'd0, t.timestamp};
   endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        inc,
   output logic [31:0] count
);

   logic [31:0] count_q;
   logic [31:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != 32'hFFFF_FFFF)) begin
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/ttc_trigger_info_reader.sv
// Pops trigger-info words, checks trigger-number continuity, streams a
// two-word event header and supervises the channel payload readout.
module ttc_trigger_info_reader
   import ttc_trig_info_defs::*;
#(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd40000000,
   parameter logic [3:0]  HDR_MARKER     = HDR_MARKER_DEFAULT
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         reset_trig_num,
   input  logic         fifo_valid,
   input  logic [127:0] fifo_data,
   output logic         fifo_ready,
   output logic         hdr_valid,
   output logic [63:0]  hdr_data,
   input  logic         hdr_ready,
   output logic         readout_start,
   input  logic         readout_done,
   output logic         event_done,
   output logic [2:0]   state,
   output logic [31:0]  seq_error_count,
   output logic [31:0]  format_error_count,
   output logic [31:0]  timeout_count,
   output logic [23:0]  last_trig_num
);

   state_e      state_q, state_d;
   logic [63:0] hdr0_q, hdr0_d;
   logic [63:0] hdr1_q, hdr1_d;
   logic        skip_ro_q, skip_ro_d;
   logic [23:0] expected_q, expected_d;
   logic [23:0] last_q, last_d;
   logic [31:0] timer_q, timer_d;

   trig_info_t  info;
   logic        pop;
   logic [23:0] check_num;
   logic        seq_inc, fmt_inc, to_inc;

   assign info       = unpack_word(fifo_data);
   // Gated by reset_n so nothing is popped while the block is held in reset.
   assign fifo_ready = reset_n && (state_q == ST_IDLE);
   assign pop        = fifo_valid && fifo_ready;
   assign check_num  = reset_trig_num ? 24'd1 : expected_q;

   always_comb begin
      state_d       = state_q;
      hdr0_d        = hdr0_q;
      hdr1_d        = hdr1_q;
      skip_ro_d     = skip_ro_q;
      last_d        = last_q;
      expected_d    = check_num;
      timer_d       = '0;
      hdr_valid     = 1'b0;
      hdr_data      = '0;
      readout_start = 1'b0;
      event_done    = 1'b0;
      seq_inc       = 1'b0;
      fmt_inc       = 1'b0;
      to_inc        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               hdr0_d    = hdr_word0(HDR_MARKER, info);
               hdr1_d    = hdr_word1(info);
               skip_ro_d = info.empty_event | info.empty_payload;
               last_d    = info.trig_num;
               seq_inc   = (info.trig_num != check_num);
               fmt_inc   = |info.reserved;
               if (!reset_trig_num) begin
                  expected_d = info.trig_num + 24'd1;
               end
               state_d = ST_HDR0;
            end
         end
         ST_HDR0: begin
            hdr_valid = 1'b1;
            hdr_data  = hdr0_q;
            if (hdr_ready) begin
               state_d = ST_HDR1;
            end
         end
         ST_HDR1: begin
            hdr_valid = 1'b1;
            hdr_data  = hdr1_q;
            if (hdr_ready) begin
               if (skip_ro_q) begin
                  state_d = ST_DONE;
               end else begin
                  readout_start = 1'b1;
                  state_d       = ST_READOUT;
               end
            end
         end
         ST_READOUT: begin
            timer_d = timer_q + 32'd1;
            if (readout_done) begin
               state_d = ST_DONE;
            end else if (timer_q == (TIMEOUT_CYCLES - 32'd1)) begin
               to_inc  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            event_done = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         hdr0_q     <= '0;
         hdr1_q     <= '0;
         skip_ro_q  <= 1'b0;
         expected_q <= 24'd1;
         last_q     <= '0;
         timer_q    <= '0;
      end else begin
         state_q    <= state_d;
         hdr0_q     <= hdr0_d;
         hdr1_q     <= hdr1_d;
         skip_ro_q  <= skip_ro_d;
         expected_q <= expected_d;
         last_q     <= last_d;
         timer_q    <= timer_d;
      end
   end

   sat_counter32 u_seq_cnt (.clk(clk), .reset_n(reset_n), .inc(seq_inc), .count(seq_error_count));
   sat_counter32 u_fmt_cnt (.clk(clk), .reset_n(reset_n), .inc(fmt_inc), .count(format_error_count));
   sat_counter32 u_to_cnt  (.clk(clk), .reset_n(reset_n), .inc(to_inc),  .count(timeout_count));

   assign state         = state_q;
   assign last_trig_num = last_q;

endmodule

// File: tb/tb_ttc_trigger_info_reader.sv
// Directed bench for ttc_trigger_info_reader with an event-level reference model.
module tb_ttc_trigger_info_reader;

   localparam int TMO = 16;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         reset_trig_num = 1'b0;
   logic         fifo_valid = 1'b0;
   logic [127:0] fifo_data = '0;
   logic         fifo_ready;
   logic         hdr_valid;
   logic [63:0]  hdr_data;
   logic         hdr_ready = 1'b1;
   logic         readout_start;
   logic         readout_done = 1'b0;
   logic         event_done;
   logic [2:0]   state;
   logic [31:0]  seq_error_count, format_error_count, timeout_count;
   logic [23:0]  last_trig_num;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int rs_count = 0;

   logic [63:0] exp_q[$];
   logic [63:0] seen_q[$];

   logic [31:0] m_seq = '0, m_fmt = '0, m_to = '0;
   logic [23:0] m_last = '0, m_exp = 24'd1;
   int          ro_left = 0;

   always #5 clk = ~clk;

   ttc_trigger_info_reader #(.TIMEOUT_CYCLES(32'd16), .HDR_MARKER(4'hA)) dut (
      .clk(clk), .reset_n(reset_n), .reset_trig_num(reset_trig_num),
      .fifo_valid(fifo_valid), .fifo_data(fifo_data), .fifo_ready(fifo_ready),
      .hdr_valid(hdr_valid), .hdr_data(hdr_data), .hdr_ready(hdr_ready),
      .readout_start(readout_start), .readout_done(readout_done), .event_done(event_done),
      .state(state), .seq_error_count(seq_error_count), .format_error_count(format_error_count),
      .timeout_count(timeout_count), .last_trig_num(last_trig_num)
   );

   function automatic logic [127:0] make_word(input logic [43:0] ts, input logic [23:0] tn,
      input logic [23:0] ec, input logic [4:0] tt, input logic ee, input logic [3:0] xa,
      input logic ep, input logic [24:0] rsv);
      return {rsv, ep, xa, ee, tt, ec, tn, ts};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: event-level bookkeeping from the word layout rules.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset_n) begin
         m_seq <= '0; m_fmt <= '0; m_to <= '0; m_last <= '0; m_exp <= 24'd1; ro_left <= 0;
         exp_q.delete();
      end else begin
         if (fifo_valid && fifo_ready) begin
            if (fifo_data[67:44] != (reset_trig_num ? 24'd1 : m_exp)) m_seq <= m_seq + 32'd1;
            if (fifo_data[127:103] != 25'd0) m_fmt <= m_fmt + 32'd1;
            m_last <= fifo_data[67:44];
            m_exp  <= reset_trig_num ? 24'd1 : fifo_data[67:44] + 24'd1;
            exp_q.push_back({4'hA, fifo_data[96:92], fifo_data[101:98], fifo_data[97],
                             fifo_data[102], 1'b0, fifo_data[67:44], fifo_data[91:68]});
            exp_q.push_back({20'd0, fifo_data[43:0]});
         end else if (reset_trig_num) begin
            m_exp <= 24'd1;
         end
         if (readout_start) begin
            ro_left <= TMO;
         end else if (ro_left > 0) begin
            if (readout_done) ro_left <= 0;
            else begin
               ro_left <= ro_left - 1;
               if (ro_left == 1) m_to <= m_to + 32'd1;
            end
         end
      end
   end

   // Compare process: header stream and status outputs every cycle.
   always @(negedge clk) begin
      if (cyc > 0) begin
         if (hdr_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL hdr_unexpected: got %0h expected no header", hdr_data);
            end else begin
               check("hdr_data", hdr_data, exp_q[0]);
               if (hdr_ready) begin
                  seen_q.push_back(hdr_data);
                  acc_cyc = cyc;
                  void'(exp_q.pop_front());
               end
            end
         end
         if (readout_start) rs_count++;
         check("seq_error_count", seq_error_count, m_seq);
         check("format_error_count", format_error_count, m_fmt);
         check("timeout_count", timeout_count, m_to);
         check("last_trig_num", last_trig_num, m_last);
      end
   end

   task automatic send_word(input logic [127:0] w);
      int n = 0;
      @(posedge clk); #1;
      fifo_valid = 1'b1;
      fifo_data  = w;
      while (1) begin
         @(negedge clk);
         if (fifo_ready) break;
         n++;
         if (n > 200) begin
            n_checks++; n_errors++;
            $display("FAIL pop_timeout: got no pop expected pop within 200 cycles");
            break;
         end
      end
      @(posedge clk); #1;
      fifo_valid = 1'b0;
   endtask

   task automatic wait_high(input string name, input int sel, output int at);
      int n = 0;
      at = -1;
      while (1) begin
         @(negedge clk);
         if ((sel == 0 && readout_start) || (sel == 1 && event_done)) begin
            at = cyc;
            break;
         end
         n++;
         if (n > 100) begin
            n_checks++; n_errors++;
            $display("FAIL %s: got no pulse expected pulse within 100 cycles", name);
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rs, ed, rs_before;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_state", state, 0);
      check("rst_fifo_ready", fifo_ready, 0);
      check("rst_hdr_valid", hdr_valid, 0);
      check("rst_hdr_data", hdr_data, 0);
      check("rst_readout_start", readout_start, 0);
      check("rst_event_done", event_done, 0);
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      check("idle_fifo_ready", fifo_ready, 1);

      // Single event with payload, readout_done 10 cycles after start
      send_word(make_word(44'h123, 24'd1, 24'd1, 5'd1, 1'b0, 4'd0, 1'b0, 25'd0));
      wait_high("t1_readout_start", 0, rs);
      repeat (10) @(posedge clk);
      #1 readout_done = 1'b1;
      @(posedge clk); #1 readout_done = 1'b0;
      wait_high("t1_event_done", 1, ed);
      check("t1_event_done_cycle", ed, rs + 11);
      check("t1_word0", seen_q[0], 64'hA080_0000_0100_0001);
      check("t1_word1", seen_q[1], 64'h0000_0000_0000_0123);
      check("t1_rs_count", rs_count, 1);
      check("t1_seq", seq_error_count, 0);

      // Continuity: 2, 4, 5 after 1
      send_word(make_word(44'h10, 24'd2, 24'd2, 5'd0, 1'b0, 4'd0, 1'b1, 25'd0));
      wait_high("t2a_event_done", 1, ed);
      check("t2_seq_after_2", seq_error_count, 0);
      send_word(make_word(44'h20, 24'd4, 24'd3, 5'd0, 1'b0, 4'd3, 1'b1, 25'd0));
      wait_high("t2b_event_done", 1, ed);
      check("t2_seq_after_4", seq_error_count, 1);
      send_word(make_word(44'h30, 24'd5, 24'd4, 5'd0, 1'b0, 4'd0, 1'b1, 25'd0));
      wait_high("t2c_event_done", 1, ed);
      check("t2_seq_after_5", seq_error_count, 1);

      // Empty event: headers only
      rs_before = rs_count;
      send_word(make_word(44'h40, 24'd6, 24'd5, 5'd3, 1'b1, 4'd0, 1'b0, 25'd0));
      wait_high("t3_event_done", 1, ed);
      check("t3_event_done_cycle", ed, acc_cyc + 1);
      check("t3_no_readout", rs_count, rs_before);

      // Back-pressure in HDR0 with a second word waiting
      hdr_ready = 1'b0;
      send_word(make_word(44'h50, 24'd7, 24'd7, 5'd2, 1'b0, 4'd0, 1'b1, 25'd0));
      fifo_valid = 1'b1;
      fifo_data  = make_word(44'h60, 24'd8, 24'd8, 5'd0, 1'b0, 4'd0, 1'b1, 25'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("t4_hold_fifo_ready", fifo_ready, 0);
         check("t4_hold_hdr_valid", hdr_valid, 1);
         check("t4_hold_hdr_data", hdr_data, 64'hA102_0000_0700_0007);
      end
      @(posedge clk); #1 hdr_ready = 1'b1;
      send_word(make_word(44'h60, 24'd8, 24'd8, 5'd0, 1'b0, 4'd0, 1'b1, 25'd0));
      wait_high("t4_event_done", 1, ed);

      // Readout timeout, max timestamp, then a following word
      send_word(make_word(44'hFFF_FFFF_FFFF, 24'd9, 24'd9, 5'd31, 1'b0, 4'hF, 1'b0, 25'd0));
      wait_high("t5_readout_start", 0, rs);
      wait_high("t5_event_done", 1, ed);
      check("t5_event_done_cycle", ed, rs + 17);
      check("t5_timeout_count", timeout_count, 1);
      send_word(make_word(44'h70, 24'd10, 24'd10, 5'd0, 1'b0, 4'd0, 1'b1, 25'd0));
      wait_high("t5b_event_done", 1, ed);

      // Trigger-number reset, then number 1 is in sequence
      @(posedge clk); #1 reset_trig_num = 1'b1;
      @(posedge clk); #1 reset_trig_num = 1'b0;
      send_word(make_word(44'h80, 24'd1, 24'd11, 5'd0, 1'b0, 4'd0, 1'b1, 25'd0));
      wait_high("t6_event_done", 1, ed);
      check("t6_seq", seq_error_count, 1);

      // Reserved bit set
      send_word(make_word(44'h90, 24'd2, 24'd12, 5'd0, 1'b0, 4'd0, 1'b1, 25'h100_0000));
      wait_high("t7_event_done", 1, ed);
      check("t7_fmt", format_error_count, 1);
      check("t7_seq", seq_error_count, 1);

      // Reset during READOUT
      send_word(make_word(44'hA0, 24'd3, 24'd13, 5'd0, 1'b0, 4'd0, 1'b0, 25'd0));
      wait_high("t8_readout_start", 0, rs);
      @(posedge clk); #1 reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("t8_state", state, 0);
      check("t8_fifo_ready", fifo_ready, 0);
      check("t8_hdr_valid", hdr_valid, 0);
      check("t8_hdr_data", hdr_data, 0);
      check("t8_readout_start", readout_start, 0);
      check("t8_event_done", event_done, 0);
      check("t8_seq", seq_error_count, 0);
      check("t8_fmt", format_error_count, 0);
      check("t8_to", timeout_count, 0);
      check("t8_last", last_trig_num, 0);
      @(posedge clk); #1 reset_n = 1'b1;

      // 24-bit wrap of the expected number
      send_word(make_word(44'hB0, 24'hFF_FFFF, 24'd1, 5'd0, 1'b0, 4'd0, 1'b1, 25'd0));
      wait_high("t9a_event_done", 1, ed);
      send_word(make_word(44'hC0, 24'd0, 24'd2, 5'd0, 1'b0, 4'd0, 1'b1, 25'd0));
      wait_high("t9b_event_done", 1, ed);
      check("t9_seq_wrap", seq_error_count, 1);
      check("t9_last", last_trig_num, 0);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
